// File: rtl/alu_pkg.sv
// Shared constants for the ALU pipeline: data width, flag bit positions and
// result-stage occupancy encodings.
package alu_pkg;

  localparam int unsigned ALU_DATA_W = 8;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  typedef logic [3:0] alu_flags_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational N/Z/C/V flag generation from an ALU result and its carry and
// overflow outputs.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W
) (
  input  logic [DATA_W-1:0] result,
  input  logic              carry,
  input  logic              ovf,
  output alu_flags_t        flags
);

  always_comb begin
    flags         = '0;
    flags[FLAG_N] = result[DATA_W-1];
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_C] = carry;
    flags[FLAG_V] = ovf;
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU output stage: captures result plus flags into a 2-entry skid
// buffer and tracks a sticky overflow flag and a saturating delivery count.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_carry,
  input  logic              in_ovf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [3:0]        out_flags,
  output logic              sticky_v,
  input  logic              clr_sticky,
  output logic [CNT_W-1:0]  result_count
);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] head_res_q, head_res_d;
  logic [DATA_W-1:0] tail_res_q, tail_res_d;
  alu_flags_t        head_flg_q, head_flg_d;
  alu_flags_t        tail_flg_q, tail_flg_d;
  logic              sticky_q, sticky_d;
  logic [CNT_W-1:0]  count_q, count_d;
  alu_flags_t        new_flags;
  logic              push, pop;

  alu_flag_gen #(
    .DATA_W (DATA_W)
  ) u_flag_gen (
    .result (in_result),
    .carry  (in_carry),
    .ovf    (in_ovf),
    .flags  (new_flags)
  );

  // Handshake outputs decode state only, so out_ready never reaches in_ready.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d    = state_q;
    head_res_d = head_res_q;
    head_flg_d = head_flg_q;
    tail_res_d = tail_res_q;
    tail_flg_d = tail_flg_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          head_res_d = in_result;
          head_flg_d = new_flags;
          state_d    = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          head_res_d = in_result;
          head_flg_d = new_flags;
        end else if (push) begin
          tail_res_d = in_result;
          tail_flg_d = new_flags;
          state_d    = ST_FULL;
        end else if (pop) begin
          // Head keeps its last value; only out_valid drops.
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          head_res_d = tail_res_q;
          head_flg_d = tail_flg_q;
          state_d    = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // A V pop in the same cycle as clr_sticky leaves the flag set.
  always_comb begin
    sticky_d = (pop & head_flg_q[FLAG_V]) | (sticky_q & ~clr_sticky);
    count_d  = count_q;
    if (pop && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      head_res_q <= '0;
      head_flg_q <= '0;
      tail_res_q <= '0;
      tail_flg_q <= '0;
      sticky_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      head_res_q <= head_res_d;
      head_flg_q <= head_flg_d;
      tail_res_q <= tail_res_d;
      tail_flg_q <= tail_flg_d;
      sticky_q   <= sticky_d;
      count_q    <= count_d;
    end
  end

  assign out_result   = head_res_q;
  assign out_flags    = head_flg_q;
  assign sticky_v     = sticky_q;
  assign result_count = count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: flag vector table, scoreboard of
// delivered entries, and directed skid/sticky/saturation/reset sequences.
module tb_alu_result_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_carry, in_ovf;
  logic [7:0] in_result;
  logic       out_valid, out_ready;
  logic [7:0] out_result;
  logic [3:0] out_flags;
  logic       sticky_v, clr_sticky;
  logic [7:0] result_count;

  // Narrow-counter instance for saturation.
  logic       v2, rdy2_in, ov2, sv2;
  logic [7:0] res2;
  logic [3:0] fl2;
  logic [1:0] count2;

  int total = 0;
  int bad   = 0;

  logic [11:0] sb_q[$];
  logic [7:0]  m_count;
  logic        m_sticky;

  typedef struct {
    logic [7:0] res;
    logic       c;
    logic       v;
    logic [3:0] flg;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  alu_result_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_carry     (in_carry),
    .in_ovf       (in_ovf),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .sticky_v     (sticky_v),
    .clr_sticky   (clr_sticky),
    .result_count (result_count)
  );

  alu_result_stage #(.DATA_W(8), .CNT_W(2)) dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (v2),
    .in_ready     (rdy2_in),
    .in_result    (8'h10),
    .in_carry     (1'b0),
    .in_ovf       (1'b0),
    .out_valid    (ov2),
    .out_ready    (1'b1),
    .out_result   (res2),
    .out_flags    (fl2),
    .sticky_v     (sv2),
    .clr_sticky   (1'b0),
    .result_count (count2)
  );

  function automatic logic [3:0] exp_flags(logic [7:0] r, logic c, logic v);
    return {r[7], (r == 8'h00), c, v};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and count/sticky model, evaluated mid-cycle on stable signals.
  always @(negedge clk) begin
    logic [11:0] e;
    logic        popped_v;
    if (!rst_n) begin
      sb_q.delete();
      m_count  = '0;
      m_sticky = 1'b0;
    end else begin
      chk("count", 32'(result_count), 32'(m_count));
      chk("sticky", 32'(sticky_v), 32'(m_sticky));
      popped_v = 1'b0;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_pop", 32'(1), 32'(0));
        end else begin
          e = sb_q.pop_front();
          chk("sb_result", 32'(out_result), 32'(e[11:4]));
          chk("sb_flags", 32'(out_flags), 32'(e[3:0]));
          popped_v = e[0];
        end
        if (m_count != 8'hFF) m_count = m_count + 8'd1;
      end
      m_sticky = popped_v | (m_sticky & ~clr_sticky);
      if (in_valid && in_ready) begin
        sb_q.push_back({in_result, exp_flags(in_result, in_carry, in_ovf)});
      end
    end
  end

  initial begin
    tbl[0] = '{res: 8'h7F, c: 1'b0, v: 1'b1, flg: 4'b0001};
    tbl[1] = '{res: 8'h00, c: 1'b1, v: 1'b0, flg: 4'b0110};
    tbl[2] = '{res: 8'hFF, c: 1'b1, v: 1'b0, flg: 4'b1010};
    tbl[3] = '{res: 8'h01, c: 1'b0, v: 1'b0, flg: 4'b0000};
    tbl[4] = '{res: 8'h80, c: 1'b1, v: 1'b1, flg: 4'b1011};
    tbl[5] = '{res: 8'h40, c: 1'b0, v: 1'b0, flg: 4'b0000};

    rst_n = 1'b0; in_valid = 0; in_result = 0; in_carry = 0; in_ovf = 0;
    out_ready = 0; clr_sticky = 0; v2 = 0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_result", 32'(out_result), 0);
    chk("rst_out_flags", 32'(out_flags), 0);
    chk("rst_sticky", 32'(sticky_v), 0);
    chk("rst_count", 32'(result_count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    #1 rst_n = 1'b1;
    cyc();

    // Zero result: Z flag, single-cycle latency
    out_ready = 1; in_valid = 1; in_result = 8'h00;
    cyc();
    in_valid = 0;
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_result", 32'(out_result), 32'h00);
    chk("t1_flags", 32'(out_flags), 32'b0100);
    cyc();
    chk("t1_count", 32'(result_count), 1);

    // Negate of -128: N and V, sticky then clear
    in_valid = 1; in_result = 8'h80; in_ovf = 1;
    cyc();
    in_valid = 0; in_ovf = 0;
    chk("t2_flags", 32'(out_flags), 32'b1001);
    cyc();
    chk("t2_sticky_set", 32'(sticky_v), 1);
    clr_sticky = 1;
    cyc();
    clr_sticky = 0;
    chk("t2_sticky_clr", 32'(sticky_v), 0);

    // Fill to FULL with downstream stalled; third push ignored
    out_ready = 0; in_valid = 1; in_result = 8'h05; in_carry = 0;
    cyc();
    in_result = 8'hFB; in_carry = 1;
    cyc();
    chk("t3_in_ready_full", 32'(in_ready), 0);
    in_result = 8'h11; in_carry = 0;
    cyc();
    in_valid = 0;
    chk("t3_hold_result", 32'(out_result), 32'h05);
    chk("t3_hold_flags", 32'(out_flags), 32'b0000);
    out_ready = 1;
    cyc();
    chk("t3_second_result", 32'(out_result), 32'hFB);
    chk("t3_second_flags", 32'(out_flags), 32'b1010);
    chk("t3_ready_back", 32'(in_ready), 1);
    cyc();
    chk("t3_empty", 32'(out_valid), 0);
    chk("t3_last_held", 32'(out_result), 32'hFB);

    // Simultaneous push and pop in ONE
    out_ready = 0; in_valid = 1; in_result = 8'h33;
    cyc();
    out_ready = 1; in_result = 8'h44;
    cyc();
    in_valid = 0;
    chk("t4_result", 32'(out_result), 32'h44);
    chk("t4_in_ready", 32'(in_ready), 1);
    chk("t4_valid", 32'(out_valid), 1);
    cyc();

    // V pop coinciding with clr_sticky keeps the flag
    out_ready = 0; in_valid = 1; in_result = 8'h80; in_ovf = 1;
    cyc();
    in_valid = 0; in_ovf = 0; out_ready = 1; clr_sticky = 1;
    cyc();
    clr_sticky = 0;
    chk("t5_sticky_wins", 32'(sticky_v), 1);

    // Flag vector table
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; in_result = tbl[i].res; in_carry = tbl[i].c; in_ovf = tbl[i].v;
      cyc();
      in_valid = 0; in_carry = 0; in_ovf = 0;
      chk($sformatf("tbl%0d_result", i), 32'(out_result), 32'(tbl[i].res));
      chk($sformatf("tbl%0d_flags", i), 32'(out_flags), 32'(tbl[i].flg));
      cyc();
    end

    // Two-bit counter saturates at 3
    v2 = 1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (i == 2) chk("sat_count_2", 32'(count2), 2);
    end
    v2 = 0;
    cyc();
    cyc();
    chk("sat_count_hold", 32'(count2), 3);

    // Asynchronous reset while FULL
    out_ready = 0; in_valid = 1; in_result = 8'h21;
    cyc();
    in_result = 8'h22;
    cyc();
    in_valid = 0;
    chk("t6_full", 32'(in_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid_async", 32'(out_valid), 0);
    chk("t6_count", 32'(result_count), 0);
    chk("t6_count2", 32'(count2), 0);
    chk("t6_result", 32'(out_result), 0);
    #2 rst_n = 1'b1;
    cyc();
    chk("t6_in_ready", 32'(in_ready), 1);
    chk("t6_still_empty", 32'(out_valid), 0);
    cyc();
    chk("sb_drained", 32'(sb_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
